// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions: fetch FSM encoding, reset PC, decode helper
package cpu_defs;

    localparam logic [15:0] CPU_RESET_PC       = 16'h0000;
    localparam logic [3:0]  CPU_IMM_CLASS_ZERO = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Bit 16 flags an immediate-class instruction for the controller.
    function automatic logic [16:0] decode_word(input logic [15:0] word,
                                                input logic [3:0]  zero_class);
        return {word[15:12] != zero_class, word};
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch with hold/stall and branch redirect
module instr_fetch
    import cpu_defs::*;
#(
    parameter logic [15:0] RESET_PC       = CPU_RESET_PC,
    parameter logic [3:0]  IMM_CLASS_ZERO = CPU_IMM_CLASS_ZERO
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    output logic [16:0] state,
    output logic        state_valid,
    output logic [15:0] pc
);

    fetch_state_t fsm;

    // mem_addr doubles as the fetch pointer; it only moves when an instruction is consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm         <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            pc          <= RESET_PC;
            state       <= 17'h0;
            state_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    fsm     <= FETCH;
                    mem_req <= 1'b1;
                end
                FETCH: begin
                    if (mem_req && mem_ack) begin
                        state       <= decode_word(mem_rdata, IMM_CLASS_ZERO);
                        pc          <= mem_addr;
                        state_valid <= 1'b1;
                        mem_req     <= 1'b0;
                        fsm         <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        mem_addr    <= branch_en ? branch_target : pc + 16'd1;
                        mem_req     <= 1'b1;
                        state_valid <= 1'b0;
                        fsm         <= FETCH;
                    end
                end
                default: begin
                    fsm         <= IDLE;
                    mem_req     <= 1'b0;
                    state_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
